// File: rtl/uart_rx_controller.sv
// ---------------------------------------------------------------------------
// uart_rx_controller
//
// Frame-level control FSM of the UART receiver. Drives the enable of the
// external edge/bit counter, samples RX_IN around mid-bit, deserializes eight
// data bits LSB first, checks optional parity and the stop bit, and delivers
// each good byte on P_DATA with a one-cycle DATA_VALID pulse.
//
// Build option:
//   RX_MAJORITY_VOTE_EN  defined   -> bit decision is the 2-of-3 majority of
//                                     the samples at M-1, M and M+1
//                        undefined -> bit decision is the sample at M
//   (M = PRESCALE>>1). Cycle timing is identical in both builds.
//
// Ports:
//   CLK         in   1  oversampling clock, PRESCALE cycles per bit
//   RST         in   1  asynchronous reset, active low
//   RX_IN       in   1  synchronized serial line, idle high
//   PRESCALE    in   5  oversampling ratio (even, 6..30), stable outside IDLE
//   PAR_EN      in   1  parity bit present (latched when a frame starts)
//   PAR_TYP     in   1  0 = even, 1 = odd (latched when a frame starts)
//   EDGE_COUNT  in   5  edge position inside the bit, 0 when disabled
//   BIT_COUNT   in   4  bit index inside the frame, 0 when disabled
//   COUNTER_EN  out  1  enable to the edge/bit counter (Mealy)
//   P_DATA      out  8  last good byte
//   DATA_VALID  out  1  one-cycle pulse when a good byte is delivered
//   PAR_ERR     out  1  parity mismatch in the current or last frame
//   STP_ERR     out  1  stop bit sampled low in the current or last frame
// ---------------------------------------------------------------------------
module uart_rx_controller (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [4:0] PRESCALE,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  input  logic [4:0] EDGE_COUNT,
  input  logic [3:0] BIT_COUNT,
  output logic       COUNTER_EN,
  output logic [7:0] P_DATA,
  output logic       DATA_VALID,
  output logic       PAR_ERR,
  output logic       STP_ERR
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t     state;
  state_t     next_state;

  logic [4:0] mid;
  logic [4:0] mid_before;
  logic [4:0] mid_after;
  logic       end_of_bit;
  logic       decide;
  logic       sample_mid;
  logic       decision_bit;
  logic [7:0] shift_reg;
  logic       par_en_q;
  logic       par_typ_q;

  assign mid        = {1'b0, PRESCALE[4:1]};
  assign mid_before = mid - 5'd1;
  assign mid_after  = mid + 5'd1;
  assign end_of_bit = (EDGE_COUNT == PRESCALE);

  // The bit decision is taken on the clock edge that closes the M+1 cycle,
  // using the live line as the third sample. Every registered effect of the
  // decision (shift, error flags, false-start abort) is therefore visible
  // from the EDGE_COUNT == M+2 cycle onward.
  assign decide = (EDGE_COUNT == mid_after);

  // Mid-bit sample, needed by both builds.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sample_mid <= 1'b0;
    end else if (EDGE_COUNT == mid) begin
      sample_mid <= RX_IN;
    end
  end

`ifdef RX_MAJORITY_VOTE_EN
  logic sample_early;

  // Early sample for the 2-of-3 vote; the late sample is RX_IN itself in
  // the decision cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sample_early <= 1'b0;
    end else if (EDGE_COUNT == mid_before) begin
      sample_early <= RX_IN;
    end
  end

  assign decision_bit = (sample_early & sample_mid) |
                        (sample_early & RX_IN)      |
                        (sample_mid   & RX_IN);
`else
  logic unused_mid_before;

  assign unused_mid_before = ^mid_before;
  assign decision_bit      = sample_mid;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the Mealy counter enable. In IDLE the enable
  // follows the line so the counter starts on the very first low cycle.
  always_comb begin
    next_state = state;
    COUNTER_EN = 1'b0;
    case (state)
      IDLE: begin
        if (!RX_IN) begin
          COUNTER_EN = 1'b1;
          next_state = START;
        end
      end
      START: begin
        COUNTER_EN = 1'b1;
        if (decide && decision_bit) begin
          next_state = IDLE;
        end else if (end_of_bit) begin
          next_state = DATA;
        end
      end
      DATA: begin
        COUNTER_EN = 1'b1;
        if (end_of_bit && (BIT_COUNT == 4'd8)) begin
          next_state = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        COUNTER_EN = 1'b1;
        if (end_of_bit) begin
          next_state = STOP;
        end
      end
      STOP: begin
        COUNTER_EN = 1'b1;
        if (end_of_bit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath. P_DATA and DATA_VALID are loaded on the STOP->DONE edge so the
  // registered pulse coincides with the single DONE cycle. Both error flags
  // are final by then because the stop decision precedes end of bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_reg  <= 8'h00;
      P_DATA     <= 8'h00;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (!RX_IN) begin
            PAR_ERR   <= 1'b0;
            STP_ERR   <= 1'b0;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
          end
        end
        DATA: begin
          if (decide) begin
            shift_reg <= {decision_bit, shift_reg[7:1]};
          end
        end
        PARITY: begin
          if (decide && (decision_bit != (^shift_reg ^ par_typ_q))) begin
            PAR_ERR <= 1'b1;
          end
        end
        STOP: begin
          if (decide && !decision_bit) begin
            STP_ERR <= 1'b1;
          end
          if (end_of_bit && !PAR_ERR && !STP_ERR) begin
            P_DATA     <= shift_reg;
            DATA_VALID <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_controller.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_controller
//
// Self-checking bench for uart_rx_controller. Contains a model of the
// upstream edge/bit counter, drives directed serial frames, and uses a
// scoreboard: each frame expected to deliver pushes {byte, cycle} into a
// queue, and a monitor pops and compares on every DATA_VALID pulse.
// ---------------------------------------------------------------------------
module tb_uart_rx_controller;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [4:0] PRESCALE;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [4:0] EDGE_COUNT;
  logic [3:0] BIT_COUNT;
  logic       COUNTER_EN;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;

  typedef struct {
    logic [7:0] data;
    int         cycle;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  uart_rx_controller dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PRESCALE   (PRESCALE),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .EDGE_COUNT (EDGE_COUNT),
    .BIT_COUNT  (BIT_COUNT),
    .COUNTER_EN (COUNTER_EN),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR)
  );

  always #5 CLK = ~CLK;

  // Cycle index: the value read after a rising edge names that cycle.
  always @(posedge CLK) cyc <= cyc + 1;

  // Model of the upstream edge/bit counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      EDGE_COUNT <= 5'd0;
      BIT_COUNT  <= 4'd0;
    end else if (!COUNTER_EN) begin
      EDGE_COUNT <= 5'd0;
      BIT_COUNT  <= 4'd0;
    end else if (EDGE_COUNT == PRESCALE) begin
      EDGE_COUNT <= 5'd1;
      BIT_COUNT  <= BIT_COUNT + 4'd1;
    end else begin
      EDGE_COUNT <= EDGE_COUNT + 5'd1;
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  // Monitor: every DATA_VALID pulse must match the oldest expected byte and
  // arrive on its expected cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (RST === 1'b1 && DATA_VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_valid: got pulse with P_DATA=0x%0h at cycle %0d, expected none",
                 P_DATA, cyc);
      end else begin
        e = exp_q.pop_front();
        check_output("p_data", {24'd0, P_DATA}, {24'd0, e.data});
        check_output("valid_cycle", cyc, e.cycle);
      end
    end
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) next_cycle();
  endtask

  task automatic drive_bit(input logic v, input int p);
    RX_IN = v;
    repeat (p) next_cycle();
  endtask

  task automatic wait_neg(input int k);
    repeat (k + 1) @(negedge CLK);
  endtask

  // Drives one full frame starting in the current cycle. t0_offset is the
  // number of cycles between the line going low and the receiver's t0.
  task automatic apply_stimulus(input logic [7:0] data, input logic par_bit,
                                input logic stop_bit, input int p,
                                input logic expect_good, input int t0_offset);
    int   start;
    int   n;
    exp_t e;
    start = cyc;
    n     = PAR_EN ? 11 : 10;
    if (expect_good) begin
      e.data  = data;
      e.cycle = start + t0_offset + n * p + 1;
      exp_q.push_back(e);
    end
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(data[i], p);
    if (PAR_EN) drive_bit(par_bit, p);
    drive_bit(stop_bit, p);
    RX_IN = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, expected test to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] b;
    RST      = 1'b0;
    RX_IN    = 1'b1;
    PRESCALE = 5'd8;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;

    $display("[TB] reset values");
    repeat (3) next_cycle();
    @(negedge CLK);
    check_output("rst_counter_en", {31'd0, COUNTER_EN}, 0);
    check_output("rst_p_data", {24'd0, P_DATA}, 0);
    check_output("rst_data_valid", {31'd0, DATA_VALID}, 0);
    check_output("rst_par_err", {31'd0, PAR_ERR}, 0);
    check_output("rst_stp_err", {31'd0, STP_ERR}, 0);
    next_cycle();
    RST = 1'b1;
    idle(4);

    $display("[TB] P=8 no parity 0xA5");
    apply_stimulus(8'hA5, 1'b0, 1'b1, 8, 1'b1, 0);
    idle(4);
    check_output("a5_par_err", {31'd0, PAR_ERR}, 0);
    check_output("a5_stp_err", {31'd0, STP_ERR}, 0);

    $display("[TB] P=8 even parity 0x3C good");
    PAR_EN  = 1'b1;
    PAR_TYP = 1'b0;
    apply_stimulus(8'h3C, 1'b0, 1'b1, 8, 1'b1, 0);
    idle(4);

    $display("[TB] P=8 even parity 0x3C bad parity");
    fork
      apply_stimulus(8'h3C, 1'b1, 1'b1, 8, 1'b0, 0);
      begin
        wait_neg(77);
        check_output("par_err_before_decision", {31'd0, PAR_ERR}, 0);
        @(negedge CLK);
        check_output("par_err_at_decision", {31'd0, PAR_ERR}, 1);
      end
    join
    idle(4);
    check_output("par_err_held", {31'd0, PAR_ERR}, 1);
    check_output("par_frame_p_data", {24'd0, P_DATA}, 32'h3C);
    check_output("par_frame_stp_err", {31'd0, STP_ERR}, 0);

    $display("[TB] P=16 no parity stop error");
    PRESCALE = 5'd16;
    PAR_EN   = 1'b0;
    fork
      apply_stimulus(8'h81, 1'b0, 1'b0, 16, 1'b0, 0);
      begin
        wait_neg(153);
        check_output("stp_err_before_decision", {31'd0, STP_ERR}, 0);
        @(negedge CLK);
        check_output("stp_err_at_decision", {31'd0, STP_ERR}, 1);
      end
    join
    idle(4);
    check_output("stp_err_held", {31'd0, STP_ERR}, 1);
    check_output("stp_frame_p_data", {24'd0, P_DATA}, 32'h3C);

    $display("[TB] P=16 odd parity back-to-back 0x00 0xFF");
    PAR_EN  = 1'b1;
    PAR_TYP = 1'b1;
    fork
      apply_stimulus(8'h00, 1'b1, 1'b1, 16, 1'b1, 0);
      begin
        wait_neg(0);
        check_output("stp_err_at_t0", {31'd0, STP_ERR}, 1);
        @(negedge CLK);
        check_output("stp_err_cleared", {31'd0, STP_ERR}, 0);
      end
    join
    drive_bit(1'b1, 1);
    apply_stimulus(8'hFF, 1'b1, 1'b1, 16, 1'b1, 1);
    idle(6);
    check_output("b2b_par_err", {31'd0, PAR_ERR}, 0);

    $display("[TB] P=8 false start");
    PRESCALE = 5'd8;
    PAR_EN   = 1'b0;
    fork
      begin
        RX_IN = 1'b0;
        next_cycle();
        next_cycle();
        RX_IN = 1'b1;
        repeat (10) next_cycle();
      end
      begin
        wait_neg(2);
        check_output("fs_en_t0p2", {31'd0, COUNTER_EN}, 1);
        repeat (3) @(negedge CLK);
        check_output("fs_en_t0p5", {31'd0, COUNTER_EN}, 1);
        @(negedge CLK);
        check_output("fs_en_t0p6", {31'd0, COUNTER_EN}, 0);
      end
    join

    $display("[TB] P=8 reset during data bit 4");
    b = 8'h5A;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(b[i], 8);
    RX_IN = 1'b1;
    repeat (3) next_cycle();
    RST = 1'b0;
    @(negedge CLK);
    check_output("mid_rst_counter_en", {31'd0, COUNTER_EN}, 0);
    check_output("mid_rst_p_data", {24'd0, P_DATA}, 0);
    check_output("mid_rst_data_valid", {31'd0, DATA_VALID}, 0);
    check_output("mid_rst_par_err", {31'd0, PAR_ERR}, 0);
    check_output("mid_rst_stp_err", {31'd0, STP_ERR}, 0);
    next_cycle();
    next_cycle();
    RST = 1'b1;
    idle(16);
    apply_stimulus(8'h5A, 1'b0, 1'b1, 8, 1'b1, 0);
    idle(10);

    check_output("pending_expected", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_controller.md
# uart_rx_controller

Frame-level control FSM of the UART receiver. It sits directly upstream of the RX edge/bit counter, driving that counter's enable and consuming its `EDGE_COUNT`/`BIT_COUNT`. It also samples `RX_IN` at mid-bit, deserializes 8 data bits LSB first, and checks parity and stop. It delivers `P_DATA` with a one-cycle `DATA_VALID` pulse to the RX output interface.

## Interface
- No parameters. Data width is fixed at 8 and LSB first.
- `CLK` input 1: oversampling clock, PRESCALE cycles per bit.
- `RST` input 1: asynchronous, active-low reset.
- `RX_IN` input 1: serial line, already synchronized; idle high.
- `PRESCALE` input 5: oversampling ratio. Legal values are even, 6..30. Must be stable whenever the FSM is not in IDLE.
- `PAR_EN` input 1: 1 means a parity bit follows the data. Latched on IDLE→START.
- `PAR_TYP` input 1: 0 = even, 1 = odd. Latched on IDLE→START.
- `EDGE_COUNT` input 5: from the edge/bit counter. 0 when disabled, otherwise 1..PRESCALE.
- `BIT_COUNT` input 4: from the counter. Increments when EDGE_COUNT==PRESCALE while enabled; 0 when disabled.
- `COUNTER_EN` output 1: enable to the counter.
- `P_DATA` output 8: last good byte.
- `DATA_VALID` output 1: one-cycle pulse when a good byte is delivered.
- `PAR_ERR` output 1: parity mismatch in the current or last frame.
- `STP_ERR` output 1: stop bit sampled 0 in the current or last frame.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, DONE. State is held in a binary-encoded register.
- Bit index is taken from BIT_COUNT: 0 = start, 1..8 = data, 9 = parity (only if PAR_EN), last = stop.
- COUNTER_EN is combinational and Mealy:
  - 1 in START, DATA, PARITY and STOP.
  - 1 in IDLE while RX_IN==0.
  - 0 in DONE and in IDLE while RX_IN==1.
- Sampling. Let M = PRESCALE>>1.
  - Capture RX_IN at EDGE_COUNT == M-1, M and M+1.
  - The decision bit is registered at EDGE_COUNT == M+2. It is the majority of the three samples (see Configuration).
- End of bit is the cycle with EDGE_COUNT==PRESCALE.
- Transitions:
  - IDLE→START when RX_IN==0. This also clears PAR_ERR and STP_ERR and latches PAR_EN/PAR_TYP.
  - START: if the decision bit is 1, go to IDLE at the decision cycle (false start). The counter resets because COUNTER_EN drops. Otherwise go to DATA at end of bit.
  - DATA: shift the decision bit into the MSB of the shift register, shifting right. At end of bit with BIT_COUNT==8, go to PARITY if PAR_EN, else STOP.
  - PARITY: the expected bit is ^shift_reg ^ PAR_TYP. On mismatch, set PAR_ERR at the decision cycle. Go to STOP at end of bit.
  - STOP: if the decision bit is 0, set STP_ERR. Go to DONE at end of bit.
  - DONE (one cycle): if !PAR_ERR && !STP_ERR, load P_DATA from the shift register and pulse DATA_VALID. Then go to IDLE unconditionally.
- An errored frame produces no DATA_VALID, and P_DATA keeps its previous value.
- Error flags hold until the next IDLE→START.
- A new start bit is recognized starting from the IDLE cycle that follows DONE.

## Timing
- Reset values: state=IDLE, COUNTER_EN=0 (with RX_IN high), P_DATA=8'h00, DATA_VALID=0, PAR_ERR=0, STP_ERR=0, shift register=0.
- t0 is the first IDLE cycle with RX_IN==0. Bit k occupies cycles t0+1+k·P .. t0+P+k·P.
- DATA_VALID is high at t0+N·P+1, with N=10 without parity and N=11 with parity. For P=8 and no parity this is t0+81.
- DATA_VALID, P_DATA, PAR_ERR and STP_ERR are registered outputs.
- Reset asserted mid-frame: all outputs go to their reset values immediately. COUNTER_EN drops while RX_IN is high, and the partial frame is discarded.
- PRESCALE changing outside IDLE is undefined. The bench must not do it.

## Configuration
- Macro `RX_MAJORITY_VOTE_EN`.
  - Defined: the decision bit is the majority of the three samples at M-1, M and M+1.
  - Undefined: the decision bit is the single sample at EDGE_COUNT==M. It is still registered at M+2, so cycle timing is identical in both builds.

## Test plan
- P=8, PAR_EN=0, byte 0xA5, stop=1 → DATA_VALID pulse at t0+81 with P_DATA=0xA5; PAR_ERR=STP_ERR=0.
- P=8, PAR_EN=1, PAR_TYP=0, byte 0x3C, parity bit 0 → DATA_VALID at t0+89, P_DATA=0x3C. Same frame with parity bit 1 → PAR_ERR=1, no DATA_VALID, P_DATA unchanged.
- P=16, PAR_EN=0, stop bit driven 0 → STP_ERR=1 from the stop decision cycle, no DATA_VALID. The flag clears at the next start.
- P=8, RX_IN low for 2 cycles then high → FSM returns to IDLE by t0+6, COUNTER_EN=0, no DATA_VALID.
- P=16, PAR_EN=1, PAR_TYP=1, frames 0x00 and 0xFF back-to-back, with the next start bit beginning the cycle after the first stop bit ends → two DATA_VALID pulses, with P_DATA 0x00 then 0xFF.
- P=8, RST pulsed low during data bit 4 → all outputs return to reset values; the next full 0x5A frame is received correctly.
